control_arranque: RTL and testbench
===================================

CONTROL_ARRANQUE -- requirements
Module: control_arranque

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 4, is the number of consecutive equal synchronized samples required to accept a new button level (legal range 1..7).
REQ-002 Parameter TIMEOUT, default 40, is the maximum number of E_ESPERA cycles allowed before an error is declared (legal range 1..63).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 BTN_START  input  1  raw asynchronous start pushbutton.
REQ-006 BTN_VEL  input  1  raw asynchronous speed-select pushbutton; each accepted press toggles the selection.
REQ-007 LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE  input  1 each  light outputs of the downstream light sequencer.
REQ-008 START  output  1  one-cycle start pulse to the sequencer.
REQ-009 VEL  output  1  speed level to the sequencer (0 slow, 1 fast).
REQ-010 RESET_LUCES  output  1  active-high synchronous reset to the sequencer.
REQ-011 OCUPADO  output  1  high while a run is in progress.
REQ-012 CORRIDAS  output  4  count of completed runs, saturating.
REQ-013 ERROR  output  1  sticky fault flag.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debounce filter whose filtered level changes only after DEBOUNCE_CICLOS consecutive synchronized samples differing from the current filtered level; any sample equal to the filtered level clears the debounce counter.
REQ-015 A press SHALL be a 0->1 transition of the filtered level; releases are ignored.
REQ-016 States: E_INICIO, E_REPOSO, E_DISPARO, E_ESPERA, E_FIN, E_ERROR; all outputs are Moore outputs decoded from the registered state, except VEL, CORRIDAS and ERROR, which are registers.
REQ-017 E_INICIO: RESET_LUCES=1; next state is E_REPOSO unconditionally.
REQ-018 E_REPOSO: OCUPADO=0; a BTN_VEL press toggles VEL; a BTN_START press moves to E_DISPARO.
REQ-019 If BTN_START and BTN_VEL presses occur in the same cycle in E_REPOSO, the block SHALL move to E_DISPARO and VEL SHALL NOT toggle.
REQ-020 BTN_VEL presses outside E_REPOSO SHALL be ignored, and VEL SHALL stay constant for the whole run.
REQ-021 E_DISPARO: START=1 and OCUPADO=1 for exactly one cycle; the timeout counter clears to 0; next state is E_ESPERA.
REQ-022 E_ESPERA: OCUPADO=1; the 6-bit timeout counter increments each cycle.
REQ-023 In E_ESPERA, all three lights high SHALL move the block to E_FIN.
REQ-024 In E_ESPERA, the block SHALL move to E_ERROR on either condition: (a) the counter reaches TIMEOUT; or (b) a single-light mismatch, meaning LUZ_VERDE alone while VEL=0, or LUZ_AMARILLA alone while VEL=1.
REQ-025 If REQ-023 and REQ-024 conditions occur in the same cycle, E_FIN SHALL take priority.
REQ-026 E_FIN: RESET_LUCES=1 and OCUPADO=0 for one cycle; CORRIDAS increments, saturating at 15; next state is E_REPOSO.
REQ-027 E_ERROR: ERROR=1, RESET_LUCES=1 and OCUPADO=0 continuously; all button presses are ignored; the only exit is RESET.
REQ-028 START SHALL never be high in two consecutive cycles.

Reset
REQ-029 While RESET=1, on each rising edge: state, synchronizers, filtered levels, debounce counters and the timeout counter SHALL clear to 0, with state set to E_INICIO; VEL=0; CORRIDAS=0; ERROR=0.
REQ-030 Reset asserted mid-run SHALL abort the run without any START, and RESET_LUCES SHALL be high in the first cycle after reset releases.

Structure
REQ-031 A shared package SHALL hold the state encodings, the defaults for DEBOUNCE_CICLOS and TIMEOUT, and the counter widths.
REQ-032 The synchronizer plus debounce logic SHALL be one sub-module, antirrebote, instantiated twice.

Verification
REQ-033 Bench SHALL cover: after reset, BTN_START held high from edge 0 -> START high for exactly the one cycle following edge 6 (N=4), with VEL=0 and OCUPADO=1.
REQ-034 Bench SHALL cover: BTN_START glitch of 3 cycles (N=4) -> no START, state remains E_REPOSO.
REQ-035 Bench SHALL cover: one BTN_VEL press then BTN_START, with a sequencer model reaching all-lights after 12 cycles -> VEL=1, then E_FIN, RESET_LUCES 1 cycle, CORRIDAS 0->1.
REQ-036 Bench SHALL cover: sequencer model that never asserts all lights -> ERROR=1 after 40 E_ESPERA cycles, and later presses ignored.
REQ-037 Bench SHALL cover: VEL=0 run with model driving LUZ_VERDE alone -> ERROR=1 on the next edge.
REQ-038 Bench SHALL cover: 17 completed runs -> CORRIDAS=15; RESET during E_ESPERA -> all outputs at reset values, then RESET_LUCES=1 in E_INICIO.

Source files
------------

// File: rtl/control_arranque_pkg.sv
// Shared definitions for the start controller: state encoding, default
// parameter values and counter widths.
package control_arranque_pkg;

  localparam int DEBOUNCE_DEF = 4;
  localparam int TIMEOUT_DEF  = 40;

  localparam int DB_CNT_W = 3;
  localparam int TO_CNT_W = 6;
  localparam int CORR_W   = 4;

  typedef enum logic [2:0] {
    E_INICIO  = 3'd0,
    E_REPOSO  = 3'd1,
    E_DISPARO = 3'd2,
    E_ESPERA  = 3'd3,
    E_FIN     = 3'd4,
    E_ERROR   = 3'd5
  } estado_t;

  // A single light that contradicts the selected speed means the sequencer is misbehaving.
  function automatic logic luz_cruzada(input logic vel, input logic roja,
                                       input logic amarilla, input logic verde);
    return (!vel && verde && !amarilla && !roja) ||
           ( vel && amarilla && !verde && !roja);
  endfunction

endpackage

// File: rtl/control_arranque_antirrebote.sv
// Two-flop synchronizer followed by a debounce filter; emits a one-cycle
// pulse whenever the filtered level rises.
module antirrebote
  import control_arranque_pkg::*;
#(
  parameter int CICLOS = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulsacion_o
);

  localparam logic [DB_CNT_W-1:0] ULTIMO = DB_CNT_W'(CICLOS - 1);

  logic [1:0]          sync_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                nivel_q, nivel_d;
  logic                pulso_q, pulso_d;

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d   = '0;
    nivel_d = nivel_q;
    pulso_d = 1'b0;
    if (sync_q[1] != nivel_q) begin
      if (cnt_q == ULTIMO) begin
        nivel_d = sync_q[1];
        pulso_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values; the synchronizer chain depends on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      nivel_q <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      nivel_q <= nivel_d;
      pulso_q <= pulso_d;
    end
  end

  assign pulsacion_o = pulso_q;

endmodule

// File: rtl/control_arranque.sv
// Start controller for a downstream light sequencer: debounced buttons,
// run supervision with timeout and light-consistency checks, run counter.
module control_arranque
  import control_arranque_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_DEF,
  parameter int TIMEOUT         = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BTN_START,
  input  logic              BTN_VEL,
  input  logic              LUZ_ROJA,
  input  logic              LUZ_AMARILLA,
  input  logic              LUZ_VERDE,
  output logic              START,
  output logic              VEL,
  output logic              RESET_LUCES,
  output logic              OCUPADO,
  output logic [CORR_W-1:0] CORRIDAS,
  output logic              ERROR
);

  localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(TIMEOUT);

  estado_t             state_q, state_d;
  logic [TO_CNT_W-1:0] to_q, to_d;
  logic [CORR_W-1:0]   corr_q, corr_d;
  logic                vel_q, vel_d;
  logic                err_q, err_d;
  logic                p_start, p_vel;
  logic                todas;

  antirrebote #(.CICLOS(DEBOUNCE_CICLOS)) u_ar_start (
    .clk(CLK), .rst(RESET), .btn_i(BTN_START), .pulsacion_o(p_start)
  );

  antirrebote #(.CICLOS(DEBOUNCE_CICLOS)) u_ar_vel (
    .clk(CLK), .rst(RESET), .btn_i(BTN_VEL), .pulsacion_o(p_vel)
  );

  assign todas = LUZ_ROJA && LUZ_AMARILLA && LUZ_VERDE;

  always_comb begin
    state_d     = state_q;
    to_d        = to_q;
    corr_d      = corr_q;
    vel_d       = vel_q;
    err_d       = err_q;
    START       = 1'b0;
    RESET_LUCES = 1'b0;
    OCUPADO     = 1'b0;
    case (state_q)
      E_INICIO: begin
        RESET_LUCES = 1'b1;
        state_d     = E_REPOSO;
      end
      E_REPOSO: begin
        // A simultaneous speed press is dropped so the run starts with the selection already shown.
        if (p_start)    state_d = E_DISPARO;
        else if (p_vel) vel_d   = !vel_q;
      end
      E_DISPARO: begin
        START   = 1'b1;
        OCUPADO = 1'b1;
        to_d    = '0;
        state_d = E_ESPERA;
      end
      E_ESPERA: begin
        OCUPADO = 1'b1;
        to_d    = to_q + TO_CNT_W'(1);
        if (todas) begin
          state_d = E_FIN;
        end else if (to_d == TO_LIM ||
                     luz_cruzada(vel_q, LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE)) begin
          state_d = E_ERROR;
          err_d   = 1'b1;
        end
      end
      E_FIN: begin
        RESET_LUCES = 1'b1;
        if (corr_q != '1) corr_d = corr_q + CORR_W'(1);
        state_d = E_REPOSO;
      end
      E_ERROR: begin
        RESET_LUCES = 1'b1;
        err_d       = 1'b1;
      end
      default: state_d = E_INICIO;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= E_INICIO;
      to_q    <= '0;
      corr_q  <= '0;
      vel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      corr_q  <= corr_d;
      vel_q   <= vel_d;
      err_q   <= err_d;
    end
  end

  assign VEL      = vel_q;
  assign CORRIDAS = corr_q;
  assign ERROR    = err_q;

endmodule

// File: tb/tb_control_arranque.sv
// Self-checking bench for control_arranque: directed sequences, a table of
// light patterns, and a randomized run against a behavioural model.
module tb_control_arranque;

  localparam int N  = 4;
  localparam int TO = 40;

  logic       CLK = 1'b0;
  logic       RESET, BTN_START, BTN_VEL;
  logic       LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE;
  logic       START, VEL, RESET_LUCES, OCUPADO, ERROR;
  logic [3:0] CORRIDAS;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  control_arranque #(.DEBOUNCE_CICLOS(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .BTN_START(BTN_START), .BTN_VEL(BTN_VEL),
    .LUZ_ROJA(LUZ_ROJA), .LUZ_AMARILLA(LUZ_AMARILLA), .LUZ_VERDE(LUZ_VERDE),
    .START(START), .VEL(VEL), .RESET_LUCES(RESET_LUCES), .OCUPADO(OCUPADO),
    .CORRIDAS(CORRIDAS), .ERROR(ERROR)
  );

  typedef struct {
    logic       vel;
    logic [2:0] rav;
    logic       exp_ocup;
    logic       exp_rl;
    logic       exp_err;
    string      nombre;
  } vec_t;

  vec_t tabla [11];

  task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    n_cmp++;
    if (actual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, actual, esperado, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic luces(input logic [2:0] rav);
    {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE} = rav;
  endtask

  task automatic aplicar_reset(input int ciclos);
    RESET = 1'b1; BTN_START = 1'b0; BTN_VEL = 1'b0;
    luces(3'b000);
    repeat (ciclos) tick();
    RESET = 1'b0;
  endtask

  task automatic pulsar_vel();
    BTN_VEL = 1'b1;
    repeat (8) tick();
    BTN_VEL = 1'b0;
    repeat (8) tick();
  endtask

  // Raises BTN_START until START shows up; returns in the START cycle.
  task automatic lanzar(input string nombre);
    bit ok = 1'b0;
    BTN_START = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (START === 1'b1) begin ok = 1'b1; break; end
    end
    BTN_START = 1'b0;
    check({nombre, "_start_seen"}, 32'(ok), 1);
  endtask

  task automatic corrida(input int idx, input int exp_corr);
    lanzar($sformatf("run%0d", idx));
    repeat (3) tick();
    luces(3'b111);
    tick();
    luces(3'b000);
    tick();
    check($sformatf("run%0d_corridas", idx), 32'(CORRIDAS), 32'(exp_corr));
    repeat (8) tick();
  endtask

  // ---------------- behavioural reference model ----------------
  logic [1:0] m_dly [2];
  logic [7:0] m_hist [2];
  int         m_nvis [2];
  bit         m_filt [2];
  bit         m_pul [2];
  bit         m_arranque, m_disparo, m_fin, m_err, m_vel;
  int         m_espera, m_corr;

  task automatic modelo_flanco();
    bit         ps, pv;
    bit [2:0]   l;
    logic [7:0] mask;
    logic       raw [2];
    logic       obs;
    ps = m_pul[0]; pv = m_pul[1];
    l = {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE};
    raw[0] = BTN_START; raw[1] = BTN_VEL;
    if (RESET) begin
      m_arranque = 1'b1; m_disparo = 1'b0; m_fin = 1'b0; m_err = 1'b0; m_vel = 1'b0;
      m_espera = -1; m_corr = 0;
      for (int b = 0; b < 2; b++) begin
        m_dly[b] = '0; m_hist[b] = '0; m_nvis[b] = 0; m_filt[b] = 1'b0; m_pul[b] = 1'b0;
      end
      return;
    end
    if (m_err) begin
    end else if (m_arranque) begin
      m_arranque = 1'b0;
    end else if (m_disparo) begin
      m_disparo = 1'b0; m_espera = 0;
    end else if (m_espera >= 0) begin
      m_espera++;
      if (l == 3'b111) begin
        m_espera = -1; m_fin = 1'b1;
      end else if (m_espera == TO || (l == 3'b001 && !m_vel) || (l == 3'b010 && m_vel)) begin
        m_espera = -1; m_err = 1'b1;
      end
    end else if (m_fin) begin
      m_fin = 1'b0;
      if (m_corr < 15) m_corr++;
    end else if (ps) begin
      m_disparo = 1'b1;
    end else if (pv) begin
      m_vel = !m_vel;
    end
    mask = 8'((1 << N) - 1);
    for (int b = 0; b < 2; b++) begin
      obs = m_dly[b][1];
      m_dly[b] = {m_dly[b][0], raw[b]};
      m_hist[b] = {m_hist[b][6:0], obs};
      m_nvis[b]++;
      m_pul[b] = 1'b0;
      if (m_nvis[b] >= N &&
          ((m_filt[b] && (m_hist[b] & mask) == 8'h00) ||
           (!m_filt[b] && (m_hist[b] & mask) == mask))) begin
        m_filt[b] = !m_filt[b];
        m_pul[b]  = m_filt[b];
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, esperas;
    bit vio_error;
    int hold_s, hold_v, r;

    tabla[0]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "v0_dark"};
    tabla[1]  = '{1'b0, 3'b001, 1'b0, 1'b1, 1'b1, "v0_green_alone"};
    tabla[2]  = '{1'b0, 3'b010, 1'b1, 1'b0, 1'b0, "v0_amber_alone"};
    tabla[3]  = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, "v0_red_alone"};
    tabla[4]  = '{1'b0, 3'b011, 1'b1, 1'b0, 1'b0, "v0_amber_green"};
    tabla[5]  = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b0, "v0_red_green"};
    tabla[6]  = '{1'b0, 3'b111, 1'b0, 1'b1, 1'b0, "v0_all"};
    tabla[7]  = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b1, "v1_amber_alone"};
    tabla[8]  = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b0, "v1_green_alone"};
    tabla[9]  = '{1'b1, 3'b110, 1'b1, 1'b0, 1'b0, "v1_red_amber"};
    tabla[10] = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, "v1_all"};

    // Reset values, then START timing with BTN_START held from edge 0.
    aplicar_reset(2);
    check("rst_start", 32'(START), 0);
    check("rst_luces", 32'(RESET_LUCES), 1);
    check("rst_ocupado", 32'(OCUPADO), 0);
    check("rst_vel", 32'(VEL), 0);
    check("rst_corridas", 32'(CORRIDAS), 0);
    check("rst_error", 32'(ERROR), 0);
    BTN_START = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("hold_start_edge%0d", k), 32'(START), (k == 6) ? 1 : 0);
      if (k == 6) begin
        check("hold_vel", 32'(VEL), 0);
        check("hold_ocupado", 32'(OCUPADO), 1);
      end
    end
    BTN_START = 1'b0;

    // Three-cycle glitch must not start a run.
    aplicar_reset(2);
    repeat (4) tick();
    BTN_START = 1'b1;
    repeat (3) tick();
    BTN_START = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (START === 1'b1 || OCUPADO === 1'b1 || RESET_LUCES === 1'b1) cnt++;
    end
    check("glitch_activity", 32'(cnt), 0);

    // Speed press, then a run completing after 12 cycles; speed press in-run ignored.
    aplicar_reset(2);
    pulsar_vel();
    check("vel_toggled", 32'(VEL), 1);
    lanzar("run_fast");
    check("run_fast_vel", 32'(VEL), 1);
    BTN_VEL = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 7) BTN_VEL = 1'b0;
    end
    check("run_fast_busy", 32'(OCUPADO), 1);
    luces(3'b111);
    tick();
    check("fin_luces", 32'(RESET_LUCES), 1);
    check("fin_ocupado", 32'(OCUPADO), 0);
    check("fin_corridas_before", 32'(CORRIDAS), 0);
    luces(3'b000);
    tick();
    check("reposo_luces", 32'(RESET_LUCES), 0);
    check("reposo_corridas", 32'(CORRIDAS), 1);
    check("reposo_vel_kept", 32'(VEL), 1);

    // Simultaneous start and speed presses: start wins, speed unchanged.
    aplicar_reset(2);
    BTN_START = 1'b1; BTN_VEL = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (START === 1'b1) cnt++;
    end
    check("both_started", 32'(cnt), 1);
    check("both_vel", 32'(VEL), 0);
    BTN_START = 1'b0; BTN_VEL = 1'b0;

    // Sequencer never lights all: timeout after exactly TO waiting cycles.
    aplicar_reset(2);
    lanzar("timeout");
    esperas = 0;
    vio_error = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ERROR === 1'b1) begin vio_error = 1'b1; break; end
      if (OCUPADO === 1'b1 && START === 1'b0) esperas++;
    end
    check("timeout_seen", 32'(vio_error), 1);
    check("timeout_cycles", 32'(esperas), TO);
    check("error_luces", 32'(RESET_LUCES), 1);
    check("error_ocupado", 32'(OCUPADO), 0);
    BTN_START = 1'b1; BTN_VEL = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) begin BTN_START = 1'b0; BTN_VEL = 1'b0; end
      if (START === 1'b1 || OCUPADO === 1'b1) cnt++;
    end
    check("error_ignores_buttons", 32'(cnt), 0);
    check("error_sticky", 32'(ERROR), 1);
    check("error_vel", 32'(VEL), 0);

    // Slow run with green alone: error one edge after the waiting cycle.
    aplicar_reset(2);
    lanzar("green");
    luces(3'b001);
    tick();
    check("green_wait_err", 32'(ERROR), 0);
    check("green_wait_busy", 32'(OCUPADO), 1);
    tick();
    check("green_err", 32'(ERROR), 1);
    luces(3'b000);

    // Table of light patterns seen during the first waiting cycle.
    for (int v = 0; v < 11; v++) begin
      aplicar_reset(2);
      if (tabla[v].vel) pulsar_vel();
      lanzar(tabla[v].nombre);
      luces(tabla[v].rav);
      tick();
      tick();
      check({tabla[v].nombre, "_ocupado"}, 32'(OCUPADO), 32'(tabla[v].exp_ocup));
      check({tabla[v].nombre, "_luces"}, 32'(RESET_LUCES), 32'(tabla[v].exp_rl));
      check({tabla[v].nombre, "_error"}, 32'(ERROR), 32'(tabla[v].exp_err));
      luces(3'b000);
    end

    // Counter saturation, then reset in the middle of a run.
    aplicar_reset(2);
    repeat (2) tick();
    for (int i = 0; i < 17; i++) corrida(i, (i + 1 > 15) ? 15 : i + 1);
    check("corridas_sat", 32'(CORRIDAS), 15);
    lanzar("abort");
    repeat (3) tick();
    check("abort_busy", 32'(OCUPADO), 1);
    RESET = 1'b1;
    tick();
    check("abort_start", 32'(START), 0);
    check("abort_ocupado", 32'(OCUPADO), 0);
    check("abort_vel", 32'(VEL), 0);
    check("abort_corridas", 32'(CORRIDAS), 0);
    check("abort_error", 32'(ERROR), 0);
    check("abort_luces_in_reset", 32'(RESET_LUCES), 1);
    RESET = 1'b0;
    check("abort_luces_after_release", 32'(RESET_LUCES), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (START === 1'b1) cnt++;
    end
    check("abort_no_start", 32'(cnt), 0);
    check("abort_reposo_luces", 32'(RESET_LUCES), 0);

    // Randomized traffic against the reference model.
    hold_s = 0; hold_v = 0;
    for (int i = 0; i < 3000; i++) begin
      RESET = (i < 2 || $urandom_range(0, 149) == 0);
      if (hold_s == 0) begin BTN_START = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 12); end
      if (hold_v == 0) begin BTN_VEL = 1'($urandom_range(0, 1)); hold_v = $urandom_range(1, 12); end
      hold_s--; hold_v--;
      r = $urandom_range(0, 99);
      if (r < 80)      luces(3'b000);
      else if (r < 90) luces(3'b111);
      else             luces(3'($urandom_range(0, 7)));
      @(posedge CLK);
      modelo_flanco();
      @(negedge CLK);
      check($sformatf("rnd%0d_start", i), 32'(START), 32'(m_disparo));
      check($sformatf("rnd%0d_ocupado", i), 32'(OCUPADO), 32'(m_disparo || m_espera >= 0));
      check($sformatf("rnd%0d_luces", i), 32'(RESET_LUCES), 32'(m_arranque || m_fin || m_err));
      check($sformatf("rnd%0d_vel", i), 32'(VEL), 32'(m_vel));
      check($sformatf("rnd%0d_corridas", i), 32'(CORRIDAS), 32'(m_corr));
      check($sformatf("rnd%0d_error", i), 32'(ERROR), 32'(m_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
